// File: rtl/clk_period_monitor.sv
// Half-period monitor for CLOCK_NUMBER generated clocks, measured in clk_i cycles.
// Optional stuck-clock detection is enabled by defining CLK_MON_TIMEOUT_EN.
module clk_period_monitor #(
  parameter int unsigned CLOCK_NUMBER = 9,
  parameter int unsigned CNT_W        = 6,
  parameter int unsigned TIMEOUT      = 48
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic [CLOCK_NUMBER-1:0]       mon_clk_i,
  input  logic                          freeze_i,
  input  logic                          clr_i,
  input  logic [CLOCK_NUMBER*CNT_W-1:0] expected_hp_i,
  output logic [CLOCK_NUMBER*CNT_W-1:0] hp_o,
  output logic [CLOCK_NUMBER-1:0]       valid_o,
  output logic [CLOCK_NUMBER-1:0]       upd_o,
  output logic [CLOCK_NUMBER-1:0]       mismatch_o,
  output logic [CLOCK_NUMBER-1:0]       stuck_o
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARMED  = 2'd1,
    LOCKED = 2'd2
  } state_e;

  // Counter stops one below all-ones so cnt+1 tops out at all-ones (">= max" marker).
  localparam logic [CNT_W-1:0] CNT_SAT = CNT_W'((1 << CNT_W) - 2);

  if (TIMEOUT > (1 << CNT_W) - 1) begin : g_timeout_range
    $error("clk_period_monitor: TIMEOUT exceeds the half-period counter range");
  end

  state_e                  state_q [CLOCK_NUMBER];
  state_e                  state_d [CLOCK_NUMBER];
  logic [CNT_W-1:0]        cnt_q   [CLOCK_NUMBER];
  logic [CNT_W-1:0]        cnt_d   [CLOCK_NUMBER];
  logic [CNT_W-1:0]        hp_q    [CLOCK_NUMBER];
  logic [CNT_W-1:0]        hp_d    [CLOCK_NUMBER];
  logic [CLOCK_NUMBER-1:0] s_q;
  logic [CLOCK_NUMBER-1:0] valid_q, valid_d;
  logic [CLOCK_NUMBER-1:0] upd_q, upd_d;
  logic [CLOCK_NUMBER-1:0] mismatch_q, mismatch_d;
  logic [CLOCK_NUMBER-1:0] tog_c;
  logic [CNT_W-1:0]        meas_c;
  logic [CNT_W-1:0]        exp_c;

  assign tog_c = mon_clk_i ^ s_q;

  // State register; s_q keeps tracking the clocks even while frozen.
  always_ff @(posedge clk_i) begin
    s_q <= mon_clk_i;
    if (!rst_ni) begin
      valid_q    <= '0;
      upd_q      <= '0;
      mismatch_q <= '0;
      for (int i = 0; i < CLOCK_NUMBER; i++) begin
        state_q[i] <= IDLE;
        cnt_q[i]   <= '0;
        hp_q[i]    <= '0;
      end
    end else begin
      valid_q    <= valid_d;
      upd_q      <= upd_d;
      mismatch_q <= mismatch_d;
      for (int i = 0; i < CLOCK_NUMBER; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
        hp_q[i]    <= hp_d[i];
      end
    end
  end

  // Per-channel next state: counter, capture FSM and sticky mismatch.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    hp_d       = hp_q;
    valid_d    = valid_q;
    upd_d      = '0;
    mismatch_d = mismatch_q;
    meas_c     = '0;
    exp_c      = '0;
    for (int i = 0; i < CLOCK_NUMBER; i++) begin
      meas_c = cnt_q[i] + CNT_W'(1);
      exp_c  = expected_hp_i[i*CNT_W +: CNT_W];
      if (!freeze_i) begin
        if (tog_c[i]) begin
          cnt_d[i] = '0;
          case (state_q[i])
            IDLE: state_d[i] = ARMED;
            ARMED, LOCKED: begin
              state_d[i] = LOCKED;
              hp_d[i]    = meas_c;
              valid_d[i] = 1'b1;
              upd_d[i]   = 1'b1;
            end
            default: state_d[i] = IDLE;
          endcase
        end else if (cnt_q[i] != CNT_SAT) begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
        // A new mismatch outranks a simultaneous clear.
        if (tog_c[i] && (state_q[i] != IDLE) && (exp_c != '0) && (meas_c != exp_c)) begin
          mismatch_d[i] = 1'b1;
        end else if (clr_i) begin
          mismatch_d[i] = 1'b0;
        end
      end
    end
  end

  // Output packing.
  always_comb begin
    hp_o = '0;
    for (int i = 0; i < CLOCK_NUMBER; i++) begin
      hp_o[i*CNT_W +: CNT_W] = hp_q[i];
    end
  end

  assign valid_o    = valid_q;
  assign upd_o      = upd_q;
  assign mismatch_o = mismatch_q;

`ifdef CLK_MON_TIMEOUT_EN
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

  logic [CLOCK_NUMBER-1:0] stuck_q, stuck_d;

  // Flag a channel once cnt+1 reaches TIMEOUT without a toggle.
  always_comb begin
    stuck_d = stuck_q;
    for (int i = 0; i < CLOCK_NUMBER; i++) begin
      if (!freeze_i) begin
        if (tog_c[i]) begin
          stuck_d[i] = 1'b0;
        end else if (cnt_q[i] >= TO_LAST) begin
          stuck_d[i] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      stuck_q <= '0;
    end else begin
      stuck_q <= stuck_d;
    end
  end

  assign stuck_o = stuck_q;
`else
  assign stuck_o = '0;
`endif

endmodule

// File: tb/tb_clk_period_monitor.sv
// Self-checking bench for clk_period_monitor: directed scenarios plus a randomized phase,
// all compared against an interval-based reference model.
module tb_clk_period_monitor;

  localparam int unsigned N  = 9;
  localparam int unsigned W  = 6;
  localparam int unsigned TO = 48;
  localparam int          HP_MAX = 63;
`ifdef CLK_MON_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   mon_clk;
  logic           freeze;
  logic           clr;
  logic [N*W-1:0] exp_bus;
  logic [N*W-1:0] hp;
  logic [N-1:0]   valid, upd, mismatch, stuck;

  clk_period_monitor #(.CLOCK_NUMBER(N), .CNT_W(W), .TIMEOUT(TO)) dut (
    .clk_i(clk), .rst_ni(rst_n), .mon_clk_i(mon_clk), .freeze_i(freeze), .clr_i(clr),
    .expected_hp_i(exp_bus), .hp_o(hp), .valid_o(valid), .upd_o(upd),
    .mismatch_o(mismatch), .stuck_o(stuck)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Clock generators: toggle every per[ch] cycles (0 = hold), paused during freeze.
  int per [N];
  int ph  [N];
  bit toggled [N];

  // Reference model: interval length in unfrozen cycles between consecutive toggles.
  bit lvl [N];
  int gap [N];
  int seen [N];
  int m_hp [N];
  bit m_valid [N], m_upd [N], m_mm [N], m_stuck [N];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_step();
    for (int ch = 0; ch < N; ch++) begin
      bit e;
      int meas;
      int ex;
      if (!rst_n) begin
        lvl[ch] = mon_clk[ch]; gap[ch] = 0; seen[ch] = 0; m_hp[ch] = 0;
        m_valid[ch] = 0; m_upd[ch] = 0; m_mm[ch] = 0; m_stuck[ch] = 0;
      end else begin
        e = (mon_clk[ch] != lvl[ch]);
        lvl[ch] = mon_clk[ch];
        m_upd[ch] = 0;
        if (!freeze) begin
          meas = (gap[ch] + 1 > HP_MAX) ? HP_MAX : gap[ch] + 1;
          ex   = int'(exp_bus[ch*W +: W]);
          if (e && seen[ch] > 0 && ex != 0 && meas != ex) m_mm[ch] = 1;
          else if (clr) m_mm[ch] = 0;
          if (e) begin
            if (seen[ch] > 0) begin
              m_hp[ch] = meas; m_valid[ch] = 1; m_upd[ch] = 1;
            end
            seen[ch] = 1;
            gap[ch] = 0;
            m_stuck[ch] = 0;
          end else begin
            if (TO_EN && gap[ch] + 1 >= TO) m_stuck[ch] = 1;
            if (gap[ch] < 1000) gap[ch]++;
          end
        end
      end
    end
  endtask

  task automatic check_outputs();
    logic [N*W-1:0] e_hp;
    logic [N-1:0]   e_v, e_u, e_m, e_s;
    for (int ch = 0; ch < N; ch++) begin
      e_hp[ch*W +: W] = W'(m_hp[ch]);
      e_v[ch] = m_valid[ch]; e_u[ch] = m_upd[ch]; e_m[ch] = m_mm[ch]; e_s[ch] = m_stuck[ch];
    end
    check("hp_o", 64'(hp), 64'(e_hp));
    check("valid_o", 64'(valid), 64'(e_v));
    check("upd_o", 64'(upd), 64'(e_u));
    check("mismatch_o", 64'(mismatch), 64'(e_m));
    check("stuck_o", 64'(stuck), 64'(e_s));
  endtask

  task automatic drive_gens();
    for (int ch = 0; ch < N; ch++) begin
      toggled[ch] = 0;
      if (!freeze && per[ch] > 0) begin
        ph[ch]++;
        if (ph[ch] >= per[ch]) begin
          mon_clk[ch] = ~mon_clk[ch];
          ph[ch] = 0;
          toggled[ch] = 1;
        end
      end
    end
  endtask

  task automatic run(input int n);
    repeat (n) begin
      @(posedge clk);
      model_step();
      @(negedge clk);
      check_outputs();
      drive_gens();
    end
  endtask

  task automatic wait_toggle(input int ch);
    int k = 0;
    do begin
      run(1);
      k++;
    end while (!toggled[ch] && k < 200);
    check($sformatf("toggle_seen_ch%0d", ch), 64'(toggled[ch]), 64'd1);
  endtask

  function automatic logic [W-1:0] hp_of(input int ch);
    return hp[ch*W +: W];
  endfunction

  initial begin
    int n;
    rst_n = 1'b0; freeze = 1'b0; clr = 1'b0; mon_clk = '0; exp_bus = '0;
    for (int ch = 0; ch < N; ch++) begin
      per[ch] = 0; ph[ch] = 0; toggled[ch] = 0;
    end

    // Reset state.
    run(2);
    check("reset_hp", 64'(hp), 64'd0);
    check("reset_valid", 64'(valid), 64'd0);

    // All channels with half-periods 3..11 and matching expectations.
    for (int ch = 0; ch < N; ch++) begin
      per[ch] = 3 + ch;
      exp_bus[ch*W +: W] = W'(3 + ch);
    end
    rst_n = 1'b1;
    run(60);
    for (int ch = 0; ch < N; ch++) check($sformatf("hp_ch%0d", ch), 64'(hp_of(ch)), 64'(3 + ch));
    check("all_valid", 64'(valid), 64'h1ff);
    check("no_mismatch", 64'(mismatch), 64'd0);

    // ch0 produces exactly one update pulse per edge.
    n = 0;
    repeat (30) begin
      run(1);
      n += int'(upd[0]);
    end
    check("ch0_upd_count", 64'(n), 64'd10);

    // ch1 half-period 5 against expectation 4; sticky set, clear, set-wins-over-clear.
    per[1] = 5;
    exp_bus[1*W +: W] = W'(4);
    run(14);
    check("mm1_set", 64'(mismatch[1]), 64'd1);
    wait_toggle(1);
    clr = 1'b1;
    run(1);
    check("mm1_clr_and_edge", 64'(mismatch[1]), 64'd1);
    run(1);
    clr = 1'b0;
    check("mm1_cleared", 64'(mismatch[1]), 64'd0);
    run(6);
    check("mm1_reset_again", 64'(mismatch[1]), 64'd1);
    exp_bus[1*W +: W] = W'(5);
    clr = 1'b1;
    run(1);
    clr = 1'b0;

    // Freeze 10 cycles mid-interval on ch4 (generators pause with it).
    wait_toggle(4);
    run(2);
    freeze = 1'b1;
    n = 0;
    repeat (10) begin
      run(1);
      n += $countones(upd);
    end
    freeze = 1'b0;
    check("freeze_no_upd", 64'(n), 64'd0);
    run(20);
    check("freeze_hp4", 64'(hp_of(4)), 64'd7);
    check("freeze_mm4", 64'(mismatch[4]), 64'd0);

    // ch2 held static: stuck detection (if enabled) and saturated measurement.
    wait_toggle(2);
    per[2] = 0;
    exp_bus[2*W +: W] = '0;
    run(70);
    check("stuck2", 64'(stuck[2]), TO_EN ? 64'd1 : 64'd0);
    per[2] = 5; ph[2] = 0;
    wait_toggle(2);
    run(1);
    check("hp2_saturated", 64'(hp_of(2)), 64'd63);
    check("stuck2_cleared", 64'(stuck[2]), 64'd0);

    // One-cycle reset while locked; valid returns after two new edges.
    rst_n = 1'b0;
    run(1);
    rst_n = 1'b1;
    check("rst_valid", 64'(valid), 64'd0);
    check("rst_hp", 64'(hp), 64'd0);
    check("rst_mm", 64'(mismatch), 64'd0);
    run(30);
    check("rst_revalid", 64'(valid), 64'h1ff);

    // Randomized: varying periods (incl. static), freeze, clear, expectations and resets.
    for (int cyc = 0; cyc < 600; cyc++) begin
      if (cyc % 50 == 0) begin
        for (int ch = 0; ch < N; ch++) begin
          per[ch] = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 20));
          case ($urandom_range(0, 2))
            0: exp_bus[ch*W +: W] = '0;
            1: exp_bus[ch*W +: W] = W'(per[ch]);
            default: exp_bus[ch*W +: W] = W'($urandom_range(1, 20));
          endcase
        end
      end
      freeze = ($urandom_range(0, 15) == 0);
      clr    = ($urandom_range(0, 19) == 0);
      rst_n  = ($urandom_range(0, 299) != 0);
      run(1);
    end
    freeze = 1'b0; clr = 1'b0; rst_n = 1'b1;
    run(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
